// File: rtl/psg_tick_pkg.sv
// Shared types and constants for the PSG fractional-N tick scheduler.
package psg_tick_pkg;

    localparam int DEF_INT_W  = 13;
    localparam int DEF_FRAC_W = 12;
    localparam int MIN_INT    = 2;

    typedef struct packed {
        logic [DEF_INT_W-1:0]  per_int;
        logic [DEF_FRAC_W-1:0] per_frac;
    } tick_cfg_t;

endpackage

// File: rtl/psg_tick_chan.sv
// One fractional-N tick channel: counter, carry accumulator, active period and wrap logic.
// Optional square-wave output when PSG_TICK_DUTY_EN is defined.
module psg_tick_chan #(
    parameter int INT_W   = 13,
    parameter int FRAC_W  = 12,
    parameter int RST_INT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              sync,
    input  logic              pend,
    input  logic [INT_W-1:0]  shd_int,
    input  logic [FRAC_W-1:0] shd_frac,
    output logic              apply,
`ifdef PSG_TICK_DUTY_EN
    output logic              clk_out,
`endif
    output logic              tick,
    output logic              upd_done
);

    logic [INT_W-1:0]  m_r;
    logic [FRAC_W:0]   acc_r;
    logic [INT_W-1:0]  int_r;
    logic [FRAC_W-1:0] frac_r;
    logic              tick_r;
    logic              upd_r;
    logic [INT_W:0]    target_s;
    logic              wrap_s;
    logic              apply_s;

    // Wrap point stretches by one cycle whenever the accumulator has carried.
    always_comb begin
        target_s = {1'b0, int_r} - (INT_W+1)'(1) + {{INT_W{1'b0}}, acc_r[FRAC_W]};
        wrap_s   = en && !sync && ({1'b0, m_r} == target_s);
        apply_s  = pend && (!en || sync || wrap_s);
    end

    // Counter, accumulator, active settings and registered pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_r    <= {INT_W{1'b0}};
            acc_r  <= {(FRAC_W+1){1'b0}};
            int_r  <= INT_W'(RST_INT);
            frac_r <= {FRAC_W{1'b0}};
            tick_r <= 1'b0;
            upd_r  <= 1'b0;
        end else begin
            tick_r <= wrap_s;
            upd_r  <= apply_s;
            if (apply_s) begin
                int_r  <= shd_int;
                frac_r <= shd_frac;
            end
            if (!en || sync) begin
                m_r   <= {INT_W{1'b0}};
                acc_r <= {(FRAC_W+1){1'b0}};
            end else if (wrap_s) begin
                m_r   <= {INT_W{1'b0}};
                // A freshly applied setting restarts the phase from its own fraction.
                acc_r <= apply_s ? {1'b0, shd_frac}
                                 : {1'b0, acc_r[FRAC_W-1:0]} + {1'b0, frac_r};
            end else begin
                m_r <= m_r + INT_W'(1);
            end
        end
    end

`ifdef PSG_TICK_DUTY_EN
    logic clk_r;

    // Square wave: high from each tick until the counter reaches half the period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_r <= 1'b0;
        end else if (!en || sync) begin
            clk_r <= 1'b0;
        end else if (wrap_s) begin
            clk_r <= 1'b1;
        end else if (m_r == (int_r >> 1)) begin
            clk_r <= 1'b0;
        end else begin
            clk_r <= clk_r;
        end
    end

    assign clk_out = clk_r;
`endif

    assign apply    = apply_s;
    assign tick     = tick_r;
    assign upd_done = upd_r;

endmodule

// File: rtl/psg_tick_scheduler.sv
// Bank of fractional-N tick channels with a shared valid/ready retune port.
// Define PSG_TICK_DUTY_EN to add the per-channel clk_o square-wave output.
module psg_tick_scheduler
    import psg_tick_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int INT_W   = psg_tick_pkg::DEF_INT_W,
    parameter int FRAC_W  = psg_tick_pkg::DEF_FRAC_W,
    parameter int RST_INT = 16,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [NUM_CH-1:0] ch_en_i,
    input  logic              sync_i,
    input  logic              cfg_valid_i,
    output logic              cfg_ready_o,
    input  logic [CH_W-1:0]   cfg_ch_i,
    input  logic [INT_W-1:0]  cfg_int_i,
    input  logic [FRAC_W-1:0] cfg_frac_i,
`ifdef PSG_TICK_DUTY_EN
    output logic [NUM_CH-1:0] clk_o,
`endif
    output logic [NUM_CH-1:0] tick_o,
    output logic [NUM_CH-1:0] upd_done_o,
    output logic              cfg_err_o
);

    logic [INT_W-1:0]  shd_int_r  [NUM_CH];
    logic [FRAC_W-1:0] shd_frac_r [NUM_CH];
    logic [NUM_CH-1:0] pending_r;
    logic [NUM_CH-1:0] apply_s;
    logic              err_r;
    logic              ready_s;
    logic              accept_s;
    logic              low_s;
    logic [INT_W-1:0]  int_clamp_s;

    // Handshake and clamping of too-short integer periods.
    always_comb begin
        ready_s = 1'b0;
        if ({1'b0, cfg_ch_i} < (CH_W+1)'(NUM_CH)) begin
            ready_s = !pending_r[cfg_ch_i];
        end else begin
            ready_s = 1'b0;
        end
        accept_s    = cfg_valid_i && ready_s;
        low_s       = cfg_int_i < INT_W'(MIN_INT);
        int_clamp_s = low_s ? INT_W'(MIN_INT) : cfg_int_i;
    end

    // Shadow registers, pending flags and sticky clamp error.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pending_r <= {NUM_CH{1'b0}};
            err_r     <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                shd_int_r[c]  <= {INT_W{1'b0}};
                shd_frac_r[c] <= {FRAC_W{1'b0}};
            end
        end else begin
            err_r <= err_r | (accept_s & low_s);
            for (int c = 0; c < NUM_CH; c++) begin
                if (accept_s && (cfg_ch_i == CH_W'(c))) begin
                    shd_int_r[c]  <= int_clamp_s;
                    shd_frac_r[c] <= cfg_frac_i;
                    pending_r[c]  <= 1'b1;
                end else if (apply_s[c]) begin
                    pending_r[c]  <= 1'b0;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        psg_tick_chan #(
            .INT_W   (INT_W),
            .FRAC_W  (FRAC_W),
            .RST_INT (RST_INT)
        ) u_chan (
            .clk      (clk_i),
            .rst_n    (rst_n_i),
            .en       (ch_en_i[g]),
            .sync     (sync_i),
            .pend     (pending_r[g]),
            .shd_int  (shd_int_r[g]),
            .shd_frac (shd_frac_r[g]),
            .apply    (apply_s[g]),
`ifdef PSG_TICK_DUTY_EN
            .clk_out  (clk_o[g]),
`endif
            .tick     (tick_o[g]),
            .upd_done (upd_done_o[g])
        );
    end

    assign cfg_ready_o = ready_s;
    assign cfg_err_o   = err_r;

endmodule

// File: tb/tb_psg_tick_scheduler.sv
// Directed self-checking bench for psg_tick_scheduler (4 channels, default widths).
module tb_psg_tick_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  ch_en;
    logic        sync;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_ch;
    logic [12:0] cfg_int;
    logic [11:0] cfg_frac;
    logic [3:0]  tick;
    logic [3:0]  upd_done;
    logic        cfg_err;
`ifdef PSG_TICK_DUTY_EN
    logic [3:0]  clk_sq;
`endif

    int vectors = 0;
    int miscompares = 0;
    int tick_cnt;

    always #5 clk = ~clk;

    psg_tick_scheduler dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .ch_en_i     (ch_en),
        .sync_i      (sync),
        .cfg_valid_i (cfg_valid),
        .cfg_ready_o (cfg_ready),
        .cfg_ch_i    (cfg_ch),
        .cfg_int_i   (cfg_int),
        .cfg_frac_i  (cfg_frac),
`ifdef PSG_TICK_DUTY_EN
        .clk_o       (clk_sq),
`endif
        .tick_o      (tick),
        .upd_done_o  (upd_done),
        .cfg_err_o   (cfg_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Expect exactly one tick on channel ch after n edges; upd_done tracks it when upd is set.
    task automatic expect_period(input int ch, input int n, input bit upd, input string tag);
        for (int i = 1; i <= n; i++) begin
            step(1);
            chk(tag, 32'(tick[ch]), 32'(i == n));
            chk({tag, "_upd"}, 32'(upd_done[ch]), 32'((i == n) && upd));
        end
    endtask

    // Write while the channel is disabled: accepted, then applied one edge later.
    task automatic write_idle(input logic [1:0] ch, input logic [12:0] ival,
                              input logic [11:0] fval, input string tag);
        cfg_valid = 1'b1; cfg_ch = ch; cfg_int = ival; cfg_frac = fval;
        #1;
        chk({tag, "_rdy"}, 32'(cfg_ready), 32'd1);
        step(1);
        chk({tag, "_busy"}, 32'(cfg_ready), 32'd0);
        cfg_valid = 1'b0;
        step(1);
        chk({tag, "_upd"}, 32'(upd_done[ch]), 32'd1);
        chk({tag, "_free"}, 32'(cfg_ready), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; ch_en = 4'd0; sync = 1'b0;
        cfg_valid = 1'b0; cfg_ch = 2'd0; cfg_int = 13'd0; cfg_frac = 12'd0;
        step(3);
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_upd", 32'(upd_done), 32'd0);
        chk("rst_err", 32'(cfg_err), 32'd0);
        chk("rst_ready", 32'(cfg_ready), 32'd1);
        rst_n = 1'b1;
        step(1);

        // Program ch0 = 4.0 and ch1 = 4.5 while idle
        write_idle(2'd0, 13'd4, 12'd0, "cfg0");
        step(1);
        chk("cfg0_upd_low", 32'(upd_done[0]), 32'd0);
        write_idle(2'd1, 13'd4, 12'd2048, "cfg1");

        // Test 1: first tick 4 cycles after enable, then every 4
        ch_en = 4'b0001;
        expect_period(0, 4, 1'b0, "t1_first");
        expect_period(0, 4, 1'b0, "t1_p2");

        // Test 3: retune mid-period takes effect only after the current period
        step(1);
        chk("t3_m1", 32'(tick[0]), 32'd0);
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_int = 13'd10; cfg_frac = 12'd0;
        #1;
        chk("t3_rdy", 32'(cfg_ready), 32'd1);
        step(1);
        chk("t3_second_blocked", 32'(cfg_ready), 32'd0);
        cfg_int = 13'd7;
        step(1);
        chk("t3_still_blocked", 32'(cfg_ready), 32'd0);
        cfg_valid = 1'b0;
        chk("t3_m3", 32'(tick[0]), 32'd0);
        step(1);
        chk("t3_old_tick", 32'(tick[0]), 32'd1);
        chk("t3_upd", 32'(upd_done[0]), 32'd1);
        expect_period(0, 10, 1'b0, "t3_p10a");
        expect_period(0, 10, 1'b0, "t3_p10b");

        // Test 2: 4.5-cycle channel gives 1820 ticks in 8192 cycles
        ch_en = 4'b0011;
        tick_cnt = 0;
        for (int i = 0; i < 8192; i++) begin
            step(1);
            if (tick[1]) tick_cnt++;
        end
        chk("t2_count", 32'(tick_cnt), 32'd1820);

        // Test 5: sync restart and sync-over-wrap
        ch_en = 4'b0000;
        step(2);
        write_idle(2'd0, 13'd5, 12'd0, "cfg5");
        write_idle(2'd1, 13'd7, 12'd0, "cfg7");
        ch_en = 4'b0011;
        step(3);
        sync = 1'b1;
        step(1);
        chk("t5_sync_notick", 32'(tick), 32'd0);
        sync = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            step(1);
            chk("t5_ch0", 32'(tick[0]), 32'(i == 5));
            chk("t5_ch1", 32'(tick[1]), 32'(i == 7));
        end
        step(2);
        chk("t5_pre_wrap", 32'(tick), 32'd0);
        sync = 1'b1;
        step(1);
        chk("t5_sync_wrap", 32'(tick), 32'd0);
        sync = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            step(1);
            chk("t5b_ch0", 32'(tick[0]), 32'(i == 5));
            chk("t5b_ch1", 32'(tick[1]), 32'(i == 7));
        end

        // Test 4: int=1 clamps to 2 and sets the sticky error
        ch_en = 4'b0010;
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_int = 13'd1; cfg_frac = 12'd0;
        step(1);
        chk("t4_err", 32'(cfg_err), 32'd1);
        cfg_valid = 1'b0;
        step(1);
        chk("t4_upd", 32'(upd_done[0]), 32'd1);
        ch_en = 4'b0011;
        expect_period(0, 2, 1'b0, "t4_p2a");
        expect_period(0, 2, 1'b0, "t4_p2b");
        expect_period(0, 2, 1'b0, "t4_p2c");
        chk("t4_err_sticky", 32'(cfg_err), 32'd1);

        // Test 6: reset with a write pending
        cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_int = 13'd9; cfg_frac = 12'd0;
        step(1);
        chk("t6_pending", 32'(cfg_ready), 32'd0);
        cfg_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t6_tick0", 32'(tick), 32'd0);
        chk("t6_upd0", 32'(upd_done), 32'd0);
        chk("t6_err0", 32'(cfg_err), 32'd0);
        chk("t6_ready", 32'(cfg_ready), 32'd1);
        ch_en = 4'b0010;
        step(2);
        rst_n = 1'b1;
        expect_period(1, 16, 1'b0, "t6_p16a");
        expect_period(1, 16, 1'b0, "t6_p16b");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
